// File: rtl/pet_memory_map_pkg.sv
// PET memory map constants shared by the banked address decoder and its control register.
package pet_memory_map_pkg;

  localparam logic [15:0] CTRL_ADDR_DEFAULT = 16'hFFF0;

  localparam logic [15:0] LOW_RAM_LIMIT   = 16'h7FFF;
  localparam logic [15:0] DISP_BASE       = 16'h8000;
  localparam logic [15:0] DISP_LIMIT      = 16'h8FFF;
  localparam logic [15:0] EDIT_ROM_BASE   = 16'h9000;
  localparam logic [15:0] EDIT_ROM_LIMIT  = 16'hAFFF;
  localparam logic [15:0] IO_BASE         = 16'hE800;
  localparam logic [15:0] IO_LIMIT        = 16'hE8FF;
  localparam logic [15:0] IO_WIN_LIMIT    = 16'hEFFF;

  localparam int CTRL_EXP_ON      = 7;
  localparam int CTRL_IO_PEEK     = 6;
  localparam int CTRL_SCREEN_PEEK = 5;
  localparam int CTRL_BANK_HI     = 3;
  localparam int CTRL_BANK_LO     = 2;
  localparam int CTRL_WP_HI       = 1;
  localparam int CTRL_WP_LO       = 0;

  localparam int IO_PIA1 = 0;
  localparam int IO_PIA2 = 1;
  localparam int IO_VIA  = 2;
  localparam int IO_CRTC = 3;

endpackage

// File: rtl/bank_ctrl_reg.sv
// Write-only bank control register; flags the strobed CPU write that targets it.
module bank_ctrl_reg
  import pet_memory_map_pkg::*;
#(
  parameter logic [15:0] CTRL_ADDR = CTRL_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        strobe,
  input  logic [15:0] addr,
  input  logic        rw_b,
  input  logic [7:0]  data_in,
  output logic        ctrl_write,
  output logic [7:0]  bank_ctrl
);

  assign ctrl_write = strobe && !rw_b && (addr == CTRL_ADDR);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bank_ctrl <= 8'h00;
    end else if (ctrl_write) begin
      bank_ctrl <= data_in;
    end
  end

endmodule

// File: rtl/banked_address_decoder.sv
// Registered PET address decoder with 8096-style expansion RAM banking.
// Optional macro EDIT_ROM_WRITE_EN makes $9000-$AFFF writable in the normal map.
module banked_address_decoder
  import pet_memory_map_pkg::*;
#(
  parameter int          RAM_ADDR_WIDTH = 17,
  parameter logic [15:0] CTRL_ADDR      = CTRL_ADDR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      strobe,
  input  logic [15:0]               addr,
  input  logic                      rw_b,
  input  logic [7:0]                data_in,
  output logic                      valid,
  output logic                      ram_enable,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      io_enable,
  output logic [3:0]                io_select,
  output logic                      mirror_enable,
  output logic                      write_enable,
  output logic [7:0]                bank_ctrl
);

  logic                      ctrl_write;
  logic                      in_low, in_disp, in_io, in_io_win, in_edit_rom;
  logic                      expansion, bank_hi, bank_bit, writable;
  logic [16:0]               phys_addr;
  logic                      nxt_ram_enable, nxt_io_enable, nxt_mirror_enable, nxt_write_enable;
  logic [3:0]                nxt_io_select;

  bank_ctrl_reg #(.CTRL_ADDR(CTRL_ADDR)) u_bank_ctrl_reg (
    .clk        (clk),
    .reset_b    (reset_b),
    .strobe     (strobe),
    .addr       (addr),
    .rw_b       (rw_b),
    .data_in    (data_in),
    .ctrl_write (ctrl_write),
    .bank_ctrl  (bank_ctrl)
  );

  assign in_low      = (addr <= LOW_RAM_LIMIT);
  assign in_disp     = (addr >= DISP_BASE) && (addr <= DISP_LIMIT);
  assign in_io       = (addr >= IO_BASE) && (addr <= IO_LIMIT);
  assign in_io_win   = (addr >= IO_BASE) && (addr <= IO_WIN_LIMIT);
  assign in_edit_rom = (addr >= EDIT_ROM_BASE) && (addr <= EDIT_ROM_LIMIT);

  // Peek-through bits punch holes in the expansion window back to the normal map.
  assign expansion = bank_ctrl[CTRL_EXP_ON] && !in_low
                     && !(in_disp && bank_ctrl[CTRL_SCREEN_PEEK])
                     && !(in_io_win && bank_ctrl[CTRL_IO_PEEK]);
  assign bank_hi   = addr[14];
  assign bank_bit  = bank_hi ? bank_ctrl[CTRL_BANK_HI] : bank_ctrl[CTRL_BANK_LO];

  always_comb begin
    nxt_ram_enable    = 1'b0;
    nxt_io_enable     = 1'b0;
    nxt_mirror_enable = 1'b0;
    nxt_io_select     = 4'b0000;
    phys_addr         = {1'b0, addr};
    writable          = 1'b0;
    if (expansion) begin
      nxt_ram_enable = 1'b1;
      phys_addr      = {1'b1, bank_bit, addr[14:0]};
      writable       = !(bank_hi ? bank_ctrl[CTRL_WP_HI] : bank_ctrl[CTRL_WP_LO]);
    end else if (in_io) begin
      nxt_io_enable = 1'b1;
      writable      = 1'b1;
      if (addr[7])      nxt_io_select[IO_CRTC] = 1'b1;
      else if (addr[6]) nxt_io_select[IO_VIA]  = 1'b1;
      else if (addr[5]) nxt_io_select[IO_PIA2] = 1'b1;
      else if (addr[4]) nxt_io_select[IO_PIA1] = 1'b1;
    end else begin
      nxt_ram_enable    = 1'b1;
      nxt_mirror_enable = in_disp;
`ifdef EDIT_ROM_WRITE_EN
      writable          = in_low || in_disp || in_edit_rom;
`else
      writable          = in_low || in_disp;
`endif
    end
    nxt_write_enable = !rw_b && writable && !ctrl_write;
  end

  // Decode results are captured only on strobed cycles; valid marks the refresh.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      valid         <= 1'b0;
      ram_enable    <= 1'b0;
      ram_addr      <= '0;
      io_enable     <= 1'b0;
      io_select     <= 4'b0000;
      mirror_enable <= 1'b0;
      write_enable  <= 1'b0;
    end else begin
      valid <= strobe;
      if (strobe) begin
        ram_enable    <= nxt_ram_enable;
        ram_addr      <= RAM_ADDR_WIDTH'(phys_addr);
        io_enable     <= nxt_io_enable;
        io_select     <= nxt_io_select;
        mirror_enable <= nxt_mirror_enable;
        write_enable  <= nxt_write_enable;
      end
    end
  end

endmodule

// File: tb/tb_banked_address_decoder.sv
// Self-checking bench for banked_address_decoder: behavioural map model plus literal spot checks.
module tb_banked_address_decoder;

  typedef struct {
    logic        ram_enable;
    logic [16:0] ram_addr;
    logic        io_enable;
    logic [3:0]  io_select;
    logic        mirror_enable;
    logic        write_enable;
  } exp_t;

`ifdef EDIT_ROM_WRITE_EN
  localparam bit EDIT_EN = 1'b1;
`else
  localparam bit EDIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_b = 1'b1;
  logic        strobe = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rw_b = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        valid, ram_enable, io_enable, mirror_enable, write_enable;
  logic [16:0] ram_addr;
  logic [3:0]  io_select;
  logic [7:0]  bank_ctrl;

  int checks = 0;
  int passes = 0;

  logic [7:0] m_ctrl = 8'h00;
  logic       m_valid = 1'b0;
  exp_t       m_out = '{1'b0, 17'h0, 1'b0, 4'h0, 1'b0, 1'b0};

  banked_address_decoder #(.RAM_ADDR_WIDTH(17)) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .strobe        (strobe),
    .addr          (addr),
    .rw_b          (rw_b),
    .data_in       (data_in),
    .valid         (valid),
    .ram_enable    (ram_enable),
    .ram_addr      (ram_addr),
    .io_enable     (io_enable),
    .io_select     (io_select),
    .mirror_enable (mirror_enable),
    .write_enable  (write_enable),
    .bank_ctrl     (bank_ctrl)
  );

  always #5 clk = ~clk;

  // Memory map expressed as address ranges and arithmetic.
  function automatic exp_t decode(input int a, input logic rw, input logic [7:0] c);
    exp_t e;
    bit   normal, hi, wr_ok;
    int   low;
    e = '{1'b0, 17'(a), 1'b0, 4'h0, 1'b0, 1'b0};
    normal = !c[7] || a < 'h8000 || (a < 'h9000 && c[5]) || (a >= 'hE800 && a < 'hF000 && c[6]);
    if (normal) begin
      if (a >= 'hE800 && a <= 'hE8FF) begin
        e.io_enable = 1'b1;
        low = (a / 16) % 16;
        if (low >= 8)      e.io_select = 4'd8;
        else if (low >= 4) e.io_select = 4'd4;
        else if (low >= 2) e.io_select = 4'd2;
        else if (low >= 1) e.io_select = 4'd1;
        wr_ok = 1'b1;
      end else begin
        e.ram_enable    = 1'b1;
        e.mirror_enable = (a >= 'h8000 && a < 'h9000);
        wr_ok = (a < 'h9000) || (EDIT_EN && a < 'hB000);
      end
    end else begin
      hi = (a >= 'hC000);
      e.ram_enable = 1'b1;
      e.ram_addr   = 17'('h10000 + ((hi ? c[3] : c[2]) ? 'h8000 : 0) + (a % 'h8000));
      wr_ok        = !(hi ? c[1] : c[0]);
    end
    e.write_enable = !rw && wr_ok && !(a == 'hFFF0);
    return e;
  endfunction

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      m_ctrl  = 8'h00;
      m_valid = 1'b0;
      m_out   = '{1'b0, 17'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    end else begin
      m_valid = strobe;
      if (strobe) begin
        m_out = decode(int'(addr), rw_b, m_ctrl);
        if (!rw_b && addr == 16'hFFF0) m_ctrl = data_in;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model-vs-DUT comparison on every falling edge.
  always @(negedge clk) begin
    checkOutput("valid", 32'(valid), 32'(m_valid));
    checkOutput("bank_ctrl", 32'(bank_ctrl), 32'(m_ctrl));
    checkOutput("ram_enable", 32'(ram_enable), 32'(m_out.ram_enable));
    checkOutput("ram_addr", 32'(ram_addr), 32'(m_out.ram_addr));
    checkOutput("io_enable", 32'(io_enable), 32'(m_out.io_enable));
    checkOutput("io_select", 32'(io_select), 32'(m_out.io_select));
    checkOutput("mirror_enable", 32'(mirror_enable), 32'(m_out.mirror_enable));
    checkOutput("write_enable", 32'(write_enable), 32'(m_out.write_enable));
  end

  task automatic applyStimulus(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    strobe = 1'b1; addr = a; rw_b = rw; data_in = d;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  logic [15:0] edges [20] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h8FFF, 16'h9000, 16'hAFFF,
                              16'hB000, 16'hBFFF, 16'hC000, 16'hE7FF, 16'hE800, 16'hE80F,
                              16'hE810, 16'hE8FF, 16'hE900, 16'hEFFF, 16'hF000, 16'hFFEF,
                              16'hFFF0, 16'hFFFF};

  initial begin
    #1 reset_b = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst valid", 32'(valid), 0);
    checkOutput("rst ram_addr", 32'(ram_addr), 0);
    checkOutput("rst bank_ctrl", 32'(bank_ctrl), 0);
    #2 reset_b = 1'b1;

    // Normal map spot checks.
    applyStimulus(16'h8123, 1'b0, 8'h00);
    checkOutput("8123 valid", 32'(valid), 1);
    checkOutput("8123 ram_en", 32'(ram_enable), 1);
    checkOutput("8123 mirror", 32'(mirror_enable), 1);
    checkOutput("8123 we", 32'(write_enable), 1);
    @(negedge clk);
    checkOutput("valid one cycle", 32'(valid), 0);
    checkOutput("hold we", 32'(write_enable), 1);
    applyStimulus(16'hE830, 1'b1, 8'h00);
    checkOutput("E830 io_sel", 32'(io_select), 32'h2);
    checkOutput("E830 io_en", 32'(io_enable), 1);
    checkOutput("E830 ram_en", 32'(ram_enable), 0);
    applyStimulus(16'hF000, 1'b0, 8'h00);
    checkOutput("F000 we", 32'(write_enable), 0);
    applyStimulus(16'h9000, 1'b0, 8'h00);
    checkOutput("9000 we", 32'(write_enable), 32'(EDIT_EN));
    applyStimulus(16'hAFFF, 1'b0, 8'h00);
    checkOutput("AFFF we", 32'(write_enable), 32'(EDIT_EN));
    applyStimulus(16'hB000, 1'b0, 8'h00);
    checkOutput("B000 we", 32'(write_enable), 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(edges[i], 1'(i % 2), 8'h00);
      applyStimulus(edges[i], 1'(1 - (i % 2)), 8'h00);
    end

    // Expansion on, both banks 0, no protection.
    applyStimulus(16'hFFF0, 1'b0, 8'h80);
    checkOutput("ctrl 80", 32'(bank_ctrl), 32'h80);
    applyStimulus(16'hC000, 1'b1, 8'h00);
    checkOutput("C000 addr", 32'(ram_addr), 32'h14000);
    applyStimulus(16'hC000, 1'b0, 8'h00);
    checkOutput("C000 we", 32'(write_enable), 1);
    applyStimulus(16'hFFF0, 1'b0, 8'h8F);
    checkOutput("ctrl wr we", 32'(write_enable), 0);
    checkOutput("ctrl wr addr", 32'(ram_addr), 32'h17FF0);
    checkOutput("ctrl 8F", 32'(bank_ctrl), 32'h8F);
    applyStimulus(16'h9000, 1'b0, 8'h00);
    checkOutput("8F 9000 addr", 32'(ram_addr), 32'h19000);
    checkOutput("8F 9000 we", 32'(write_enable), 0);
    applyStimulus(16'hCFFF, 1'b0, 8'h00);
    checkOutput("8F CFFF addr", 32'(ram_addr), 32'h1CFFF);
    checkOutput("8F CFFF we", 32'(write_enable), 0);
    applyStimulus(16'hFFF0, 1'b1, 8'h00);
    checkOutput("ctrl read keeps", 32'(bank_ctrl), 32'h8F);
    applyStimulus(16'hFFF0, 1'b0, 8'hE0);
    applyStimulus(16'h8000, 1'b1, 8'h00);
    checkOutput("E0 8000 mirror", 32'(mirror_enable), 1);
    checkOutput("E0 8000 addr", 32'(ram_addr), 32'h08000);
    applyStimulus(16'hE810, 1'b1, 8'h00);
    checkOutput("E0 E810 io_sel", 32'(io_select), 32'h1);
    applyStimulus(16'hA000, 1'b1, 8'h00);
    checkOutput("E0 A000 addr", 32'(ram_addr), 32'h12000);
    for (int i = 0; i < 20; i++) applyStimulus(edges[i], 1'b0, 8'h00);

    // Reset in the middle of a strobed cycle discards the decode.
    @(negedge clk);
    strobe = 1'b1; addr = 16'h8123; rw_b = 1'b0;
    #2 reset_b = 1'b0;
    #1;
    checkOutput("midrst bank_ctrl", 32'(bank_ctrl), 0);
    checkOutput("midrst ram_en", 32'(ram_enable), 0);
    checkOutput("midrst ram_addr", 32'(ram_addr), 0);
    @(negedge clk);
    strobe = 1'b0;
    #2 reset_b = 1'b1;

    // Randomized traffic including back-to-back strobes and control writes.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      strobe = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       begin addr = 16'hFFF0; rw_b = 1'b0; data_in = 8'($urandom); end
        1, 2, 3: begin addr = edges[$urandom_range(0, 19)]; rw_b = 1'($urandom); end
        default: begin addr = 16'($urandom); rw_b = 1'($urandom); end
      endcase
    end
    @(negedge clk);
    strobe = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
